// File: rtl/fb_scanout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fb_scanout_ctrl
// Purpose  : Frame buffer scan-out controller. Generates raster video timing,
//            reads active pixels from the frame buffer in raster order and
//            hands every non-read cycle of the single buffer port to upstream
//            writers through a valid/ready handshake.
// Ports    : clk, reset_n         - pixel clock, async active-low reset
//            enable               - run (1) / hold timing idle (0)
//            wr_valid/wr_ready    - upstream write handshake
//            wr_addr/wr_data      - upstream pixel index and RGB888 data
//            fb_addr/fb_we/fb_wdata/fb_rdata - frame buffer port
//            vid_hsync/vid_vsync/vid_de/vid_rgb - display stream
//            frame_start          - pulse with the first active pixel
// Revision : 1.0 - initial release
// ============================================================================
module fb_scanout_ctrl #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter int   ADDR_W   = 21,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [23:0]       fb_wdata,
  input  logic [23:0]       fb_rdata,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_de,
  output logic [23:0]       vid_rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0]    c_H_ACT   = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0]    c_H_SYNCS = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0]    c_H_SYNCE = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [H_W-1:0]    c_H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]    c_V_ACT   = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0]    c_V_SYNCS = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0]    c_V_SYNCE = V_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [V_W-1:0]    c_V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] c_NPIX    = ADDR_W'(H_ACTIVE * V_ACTIVE);

  // Stage 0: timing counters and linear pixel index of the current position
  logic              r_run;
  logic [H_W-1:0]    r_h_cnt;
  logic [V_W-1:0]    r_v_cnt;
  logic [ADDR_W-1:0] r_pix;

  // Stage 1: read slot on the buffer port
  logic              r_act1;
  logic              r_hs1;
  logic              r_vs1;
  logic              r_fs1;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_ready;

  // Stage 2: video outputs
  logic              r_de;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_fs;
  logic [23:0]       r_rgb;

  logic w_act0;
  logic w_hs0;
  logic w_vs0;
  logic w_fs0;
  logic w_h_wrap;
  logic w_v_wrap;

  // r_run delays the first count by one clock so stage 0 presents (0,0)
  // for a full cycle after enable rises.
  assign w_act0   = r_run && (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_hs0    = r_run && (r_h_cnt >= c_H_SYNCS) && (r_h_cnt < c_H_SYNCE);
  assign w_vs0    = r_run && (r_v_cnt >= c_V_SYNCS) && (r_v_cnt < c_V_SYNCE);
  assign w_fs0    = w_act0 && (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_h_wrap = (r_h_cnt == c_H_LAST);
  assign w_v_wrap = (r_v_cnt == c_V_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run   <= 1'b0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_pix   <= '0;
    end else if (!enable) begin
      r_run   <= 1'b0;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_pix   <= '0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        if (w_h_wrap) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
        // Index restarts at frame wrap; otherwise it only moves on active pixels
        if (w_h_wrap && w_v_wrap) begin
          r_pix <= '0;
        end else if (w_act0) begin
          r_pix <= r_pix + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_act1     <= 1'b0;
      r_hs1      <= 1'b0;
      r_vs1      <= 1'b0;
      r_fs1      <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_ready <= 1'b0;
    end else begin
      r_act1     <= enable && w_act0;
      r_hs1      <= enable && w_hs0;
      r_vs1      <= enable && w_vs0;
      r_fs1      <= enable && w_fs0;
      r_rd_addr  <= (enable && w_act0) ? r_pix : '0;
      // Registered from stage 0 so ready is known a cycle ahead of the slot
      r_wr_ready <= !(enable && w_act0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_fs    <= 1'b0;
      r_rgb   <= '0;
    end else if (!enable) begin
      r_de    <= 1'b0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_fs    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_de    <= r_act1;
      r_hsync <= r_hs1 ? SYNC_POL : ~SYNC_POL;
      r_vsync <= r_vs1 ? SYNC_POL : ~SYNC_POL;
      r_fs    <= r_fs1;
      r_rgb   <= r_act1 ? fb_rdata : '0;
    end
  end

  // Port mux: read slot has priority; r_wr_ready is low only during reset
  // or a read, so the port is fully quiet while in reset.
  always_comb begin
    fb_addr  = '0;
    fb_we    = 1'b0;
    fb_wdata = '0;
    if (r_act1) begin
      fb_addr = r_rd_addr;
    end else if (r_wr_ready) begin
      fb_addr  = wr_addr;
      fb_wdata = wr_data;
      fb_we    = wr_valid && (wr_addr < c_NPIX);
    end
  end

  assign wr_ready    = r_wr_ready;
  assign vid_de      = r_de;
  assign vid_hsync   = r_hsync;
  assign vid_vsync   = r_vsync;
  assign vid_rgb     = r_rgb;
  assign frame_start = r_fs;

endmodule
`default_nettype wire
